// File: rtl/half_duplex_rpi_bus_controller_if.sv
// rtl/half_duplex_rpi_bus_controller_if.sv - command, response and strobe signals of the RPi bus controller
interface half_duplex_rpi_bus_controller_if #(
  parameter int BUS_WIDTH = 16,
  parameter int TRANSACTIONS_PER_DATA_WORD = 2,
  parameter int TRANSACTIONS_PER_ADDRESS_WORD = 1
);
  localparam int MAX_TRANS = (TRANSACTIONS_PER_DATA_WORD > TRANSACTIONS_PER_ADDRESS_WORD) ?
                             TRANSACTIONS_PER_DATA_WORD : TRANSACTIONS_PER_ADDRESS_WORD;
  localparam int CMD_WIDTH = BUS_WIDTH * MAX_TRANS;
  localparam int RSP_WIDTH = BUS_WIDTH * TRANSACTIONS_PER_DATA_WORD;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_type;
  logic [CMD_WIDTH-1:0] cmd_data;
  logic                 rsp_valid;
  logic [RSP_WIDTH-1:0] rsp_data;
  logic                 busy;
  logic                 read;
  logic                 register_select;
  logic                 enable;
  logic [31:0]          cmd_errors;

  // master is the controller itself; slave is the user logic and the observing peripheral
  modport master (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy, read, register_select, enable, cmd_errors
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy, read, register_select, enable, cmd_errors
  );
endinterface

// File: rtl/half_duplex_rpi_bus_controller.sv
// rtl/half_duplex_rpi_bus_controller.sv - initiator end of the half-duplex RPi parallel bus
module half_duplex_rpi_bus_controller #(
  parameter int BUS_WIDTH = 16,
  parameter int TRANSACTIONS_PER_DATA_WORD = 2,
  parameter int TRANSACTIONS_PER_ADDRESS_WORD = 1,
  parameter int SETUP_CYCLES = 2,
  parameter int ENABLE_HIGH_CYCLES = 8,
  parameter int HOLD_CYCLES = 8,
  parameter int TURNAROUND_CYCLES = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  half_duplex_rpi_bus_controller_if.master  io,
  inout  wire [BUS_WIDTH-1:0]               bus
);
  localparam int MAX_TRANS = (TRANSACTIONS_PER_DATA_WORD > TRANSACTIONS_PER_ADDRESS_WORD) ?
                             TRANSACTIONS_PER_DATA_WORD : TRANSACTIONS_PER_ADDRESS_WORD;
  localparam int CMD_WIDTH = BUS_WIDTH * MAX_TRANS;
  localparam int RSP_WIDTH = BUS_WIDTH * TRANSACTIONS_PER_DATA_WORD;
  localparam int MAX_SE = (SETUP_CYCLES > ENABLE_HIGH_CYCLES) ? SETUP_CYCLES : ENABLE_HIGH_CYCLES;
  localparam int MAX_HT = (HOLD_CYCLES > TURNAROUND_CYCLES) ? HOLD_CYCLES : TURNAROUND_CYCLES;
  localparam int MAX_TIMER = (MAX_SE > MAX_HT) ? MAX_SE : MAX_HT;
  localparam int TIMER_WIDTH = (MAX_TIMER > 1) ? $clog2(MAX_TIMER) : 1;
  localparam int INDEX_WIDTH = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;

  localparam logic [TIMER_WIDTH-1:0] SETUP_LOAD  = TIMER_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] STROBE_LOAD = TIMER_WIDTH'(ENABLE_HIGH_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] HOLD_LOAD   = TIMER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TURN_LOAD   =
    TIMER_WIDTH'((TURNAROUND_CYCLES > 0) ? TURNAROUND_CYCLES - 1 : 0);
  localparam logic [INDEX_WIDTH-1:0] ADDR_LAST = INDEX_WIDTH'(TRANSACTIONS_PER_ADDRESS_WORD - 1);
  localparam logic [INDEX_WIDTH-1:0] DATA_LAST = INDEX_WIDTH'(TRANSACTIONS_PER_DATA_WORD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

  state_t                 state, state_d;
  logic [TIMER_WIDTH-1:0] timer, timer_d;
  logic [INDEX_WIDTH-1:0] index, index_d;
  logic [CMD_WIDTH-1:0]   word, word_d;
  logic [RSP_WIDTH-1:0]   capture, capture_d;
  logic [RSP_WIDTH-1:0]   rsp_data, rsp_data_d;
  logic [BUS_WIDTH-1:0]   bus_out, bus_out_d;
  logic                   enable, enable_d;
  logic                   read, read_d;
  logic                   register_select, register_select_d;
  logic                   drive_enable, drive_enable_d;
  logic                   rsp_valid, rsp_valid_d;
  logic [31:0]            cmd_errors, cmd_errors_d;

  function automatic logic [BUS_WIDTH-1:0] halfword(input logic [CMD_WIDTH-1:0] w,
                                                    input logic [INDEX_WIDTH-1:0] k);
    return w[int'(k)*BUS_WIDTH +: BUS_WIDTH];
  endfunction

  always_comb begin
    state_d           = state;
    timer_d           = (timer != '0) ? timer - 1'b1 : timer;
    index_d           = index;
    word_d            = word;
    capture_d         = capture;
    rsp_data_d        = rsp_data;
    bus_out_d         = bus_out;
    enable_d          = enable;
    read_d            = read;
    register_select_d = register_select;
    drive_enable_d    = drive_enable;
    rsp_valid_d       = 1'b0;
    cmd_errors_d      = cmd_errors;

    case (state)
      IDLE: begin
        if (io.cmd_valid) begin
          if (io.cmd_type == 2'd3) begin
            if (cmd_errors != 32'hFFFF_FFFF) cmd_errors_d = cmd_errors + 32'd1;
          end else begin
            word_d            = io.cmd_data;
            index_d           = (io.cmd_type == 2'd0) ? ADDR_LAST : DATA_LAST;
            bus_out_d         = halfword(io.cmd_data, index_d);
            read_d            = (io.cmd_type == 2'd2);
            register_select_d = (io.cmd_type != 2'd0);
            drive_enable_d    = (io.cmd_type != 2'd2);
            timer_d           = SETUP_LOAD;
            state_d           = SETUP;
          end
        end
      end
      SETUP: begin
        if (timer == '0) begin
          enable_d = 1'b1;
          timer_d  = STROBE_LOAD;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        if (timer == '0) begin
          // the peripheral has had the whole strobe to settle its read data
          if (read) capture_d[int'(index)*BUS_WIDTH +: BUS_WIDTH] = bus;
          enable_d = 1'b0;
          timer_d  = HOLD_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (timer == '0) begin
          if (index != '0) begin
            index_d   = index - 1'b1;
            bus_out_d = halfword(word, index_d);
            timer_d   = SETUP_LOAD;
            state_d   = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            if (read) begin
              rsp_data_d     = capture;
              read_d         = 1'b0;
              drive_enable_d = 1'b0;
              timer_d        = TURN_LOAD;
              state_d        = (TURNAROUND_CYCLES > 0) ? TURN : IDLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      TURN: begin
        if (timer == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      timer           <= '0;
      index           <= '0;
      word            <= '0;
      capture         <= '0;
      rsp_data        <= '0;
      bus_out         <= '0;
      enable          <= 1'b0;
      read            <= 1'b0;
      register_select <= 1'b0;
      drive_enable    <= 1'b0;
      rsp_valid       <= 1'b0;
      cmd_errors      <= '0;
    end else begin
      state           <= state_d;
      timer           <= timer_d;
      index           <= index_d;
      word            <= word_d;
      capture         <= capture_d;
      rsp_data        <= rsp_data_d;
      bus_out         <= bus_out_d;
      enable          <= enable_d;
      read            <= read_d;
      register_select <= register_select_d;
      drive_enable    <= drive_enable_d;
      rsp_valid       <= rsp_valid_d;
      cmd_errors      <= cmd_errors_d;
    end
  end

  assign bus                = drive_enable ? bus_out : {BUS_WIDTH{1'bz}};
  assign io.cmd_ready       = (state == IDLE);
  assign io.busy            = (state != IDLE);
  assign io.rsp_valid       = rsp_valid;
  assign io.rsp_data        = rsp_data;
  assign io.read            = read;
  assign io.register_select = register_select;
  assign io.enable          = enable;
  assign io.cmd_errors      = cmd_errors;
endmodule

// File: tb/tb_half_duplex_rpi_bus_controller.sv
// tb/tb_half_duplex_rpi_bus_controller.sv - scoreboard bench for the RPi bus controller
module tb_half_duplex_rpi_bus_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  half_duplex_rpi_bus_controller_if #(
    .BUS_WIDTH(16), .TRANSACTIONS_PER_DATA_WORD(2), .TRANSACTIONS_PER_ADDRESS_WORD(1)
  ) ifc ();

  wire  [15:0] bus;
  logic [31:0] rd_word = 32'h0;
  logic        rd_idx  = 1'b1;

  // peripheral model: drives the selected read halfword whenever the controller reads
  assign bus = ifc.read ? (rd_idx ? rd_word[31:16] : rd_word[15:0]) : 16'hzzzz;

  half_duplex_rpi_bus_controller #(
    .BUS_WIDTH(16), .TRANSACTIONS_PER_DATA_WORD(2), .TRANSACTIONS_PER_ADDRESS_WORD(1),
    .SETUP_CYCLES(2), .ENABLE_HIGH_CYCLES(8), .HOLD_CYCLES(8), .TURNAROUND_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(ifc),
    .bus(bus)
  );

  typedef struct { logic is_read; logic [31:0] data; int latency; } rsp_t;
  typedef struct { logic register_select; logic [15:0] value; } strobe_t;

  rsp_t    rsp_q[$];
  strobe_t strobe_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int viol = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: actual timeout required completion", name);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  logic        en_prev = 1'b0, rd_prev = 1'b0, rs_prev = 1'b0, de_prev = 1'b0;
  logic [15:0] bus_prev = 16'h0;

  always @(negedge clock) begin
    rsp_t    r;
    strobe_t s;
    if (!reset) begin
      if (ifc.cmd_valid && ifc.cmd_ready && ifc.cmd_type != 2'd3) begin
        accept_cyc = cyc;
        if (ifc.cmd_type == 2'd2) rd_idx = 1'b1;
      end
      if (dut.drive_enable && ifc.read) viol++;
      if (ifc.enable && en_prev &&
          (bus !== bus_prev || ifc.read !== rd_prev || ifc.register_select !== rs_prev ||
           dut.drive_enable !== de_prev)) viol++;
      if (ifc.enable && !en_prev) begin
        if (ifc.read !== rd_prev || ifc.register_select !== rs_prev || bus !== bus_prev) viol++;
        if (!ifc.read) begin
          if (strobe_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: actual bus 0x%0h required none", bus);
          end else begin
            s = strobe_q.pop_front();
            check("strobe_register_select", 64'(ifc.register_select), 64'(s.register_select));
            check("strobe_bus", 64'(bus), 64'(s.value));
          end
        end
      end
      if (!ifc.enable && en_prev && ifc.read) rd_idx = ~rd_idx;
      if (ifc.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: actual rsp_valid=1 required 0");
        end else begin
          r = rsp_q.pop_front();
          check("rsp_latency", 64'(cyc - accept_cyc), 64'(r.latency));
          if (r.is_read) check("rsp_data", 64'(ifc.rsp_data), 64'(r.data));
        end
      end
    end
    en_prev  = ifc.enable;
    rd_prev  = ifc.read;
    rs_prev  = ifc.register_select;
    de_prev  = dut.drive_enable;
    bus_prev = bus;
  end

  task automatic issue(input logic [1:0] t, input logic [31:0] d, output int acc);
    bit ok = 0;
    acc = 0;
    @(posedge clock);
    #1;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_type  = t;
    ifc.cmd_data  = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (ifc.cmd_ready) begin
        ok  = 1;
        acc = cyc;
      end
    end
    if (!ok) timeout("issue_accept");
    @(posedge clock);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int en_cycles, output logic de_seen);
    bit ok = 0;
    en_cycles = 0;
    de_seen   = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (ifc.enable) en_cycles++;
      if (dut.drive_enable) de_seen = 1'b1;
      if (ifc.cmd_ready) ok = 1;
    end
    if (!ok) timeout("wait_idle");
  endtask

  initial begin
    int   a, a2, en_cnt;
    logic de_seen;
    bit   got;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_type  = 2'd0;
    ifc.cmd_data  = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
    check("reset_busy", 64'(ifc.busy), 64'd0);
    check("reset_enable", 64'(ifc.enable), 64'd0);
    check("reset_read", 64'(ifc.read), 64'd0);
    check("reset_register_select", 64'(ifc.register_select), 64'd0);
    check("reset_rsp_data", 64'(ifc.rsp_data), 64'd0);
    check("reset_cmd_errors", 64'(ifc.cmd_errors), 64'd0);

    // address write: single strobe, 1*(2+8+8)+1 cycles
    strobe_q.push_back('{1'b0, 16'h0003});
    rsp_q.push_back('{1'b0, 32'h0, 19});
    issue(2'd0, 32'h0000_0003, a);
    wait_idle(en_cnt, de_seen);
    check("addr_enable_cycles", 64'(en_cnt), 64'd8);

    // data write: high halfword first
    strobe_q.push_back('{1'b1, 16'h3123});
    strobe_q.push_back('{1'b1, 16'h1507});
    rsp_q.push_back('{1'b0, 32'h0, 37});
    issue(2'd1, 32'h3123_1507, a);
    wait_idle(en_cnt, de_seen);
    check("write_enable_cycles", 64'(en_cnt), 64'd16);

    // data read followed by two turnaround cycles
    rd_word = 32'hDEAD_BEEF;
    rsp_q.push_back('{1'b1, 32'hDEAD_BEEF, 37});
    issue(2'd2, 32'h0, a);
    got = 0;
    de_seen = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clock);
      if (dut.drive_enable) de_seen = 1'b1;
      if (ifc.rsp_valid) got = 1;
    end
    if (!got) timeout("read_rsp");
    check("read_no_drive", 64'(de_seen), 64'd0);
    check("turn1_cmd_ready", 64'(ifc.cmd_ready), 64'd0);
    check("turn1_read", 64'(ifc.read), 64'd0);
    @(negedge clock);
    check("turn2_cmd_ready", 64'(ifc.cmd_ready), 64'd0);
    @(negedge clock);
    check("turn_done_cmd_ready", 64'(ifc.cmd_ready), 64'd1);

    // read with a write queued behind it: write waits for the turnaround
    rd_word = 32'h1234_5678;
    rsp_q.push_back('{1'b1, 32'h1234_5678, 37});
    strobe_q.push_back('{1'b1, 16'hA5A5});
    strobe_q.push_back('{1'b1, 16'h5A5A});
    rsp_q.push_back('{1'b0, 32'h0, 37});
    issue(2'd2, 32'h0, a);
    issue(2'd1, 32'hA5A5_5A5A, a2);
    check("queued_write_accept_gap", 64'(a2 - a), 64'd39);
    wait_idle(en_cnt, de_seen);

    // illegal commands
    issue(2'd3, 32'hFFFF_FFFF, a);
    issue(2'd3, 32'h0, a);
    @(negedge clock);
    check("cmd_errors_two", 64'(ifc.cmd_errors), 64'd2);
    check("illegal_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
    check("illegal_no_enable", 64'(ifc.enable), 64'd0);

    // reset in the middle of a strobe
    strobe_q.push_back('{1'b1, 16'hCAFE});
    issue(2'd1, 32'hCAFE_F00D, a);
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clock);
      if (ifc.enable) got = 1;
    end
    if (!got) timeout("strobe_start");
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_enable", 64'(ifc.enable), 64'd0);
    check("abort_read", 64'(ifc.read), 64'd0);
    check("abort_drive_enable", 64'(dut.drive_enable), 64'd0);
    check("abort_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check("abort_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
    check("abort_cmd_errors", 64'(ifc.cmd_errors), 64'd0);
    check("abort_rsp_data", 64'(ifc.rsp_data), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    strobe_q.push_back('{1'b0, 16'h0005});
    rsp_q.push_back('{1'b0, 32'h0, 19});
    issue(2'd0, 32'h0000_0005, a);
    wait_idle(en_cnt, de_seen);
    check("post_reset_enable_cycles", 64'(en_cnt), 64'd8);

    repeat (3) @(negedge clock);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    check("strobe_queue_drained", 64'(strobe_q.size()), 64'd0);
    check("bus_protocol_violations", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end
endmodule
